spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
- Parametrised full-duplex SPI master.
- Generalises the fixed 16-bit mode-0 master to configurable word width, clock divider, all four CPOL/CPHA modes, and multiple chip selects.
- Also adds programmable CS setup/hold/gap timing.
- Sits between user logic (start/busy/done handshake) and external SPI slaves on the board.

Parameters:
- DATA_W, 16: bits per frame; legal range 4..32.
- HALF_DIV, 25: sys_clk cycles per spi_clk half-period; minimum 1.
- NUM_CS, 4: number of chip-select lines; minimum 1.
- GAP_CYC, 8: sys_clk cycles CS stays high after a frame before done; minimum 1.
- CS_W, max(1, clog2(NUM_CS)): local, width of cs_sel.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a frame; sampled only in IDLE.
- cpol  in  1  clock polarity; latched at start.
- cpha  in  1  clock phase; latched at start.
- cs_sel  in  CS_W  slave index; latched at start.
- tx_data  in  DATA_W  word to send; latched at start.
- rx_data  out  DATA_W  last received word.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of frame.
- spi_csn  out  NUM_CS  active-low chip selects.
- spi_clk  out  1  serial clock.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.

Behaviour:
- Reset values: spi_csn all 1, spi_clk 0, spi_mosi 0, rx_data 0, busy 0, done 0, state IDLE.
- rst is asynchronous; asserting it mid-frame aborts immediately to these values.
- States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE. All outputs are registered.
- IDLE: spi_clk = latched cpol (0 after reset), spi_csn all 1. On start=1: latch tx_data, cpol, cpha, cs_sel into registers, go to SETUP. start in any other state is ignored.
- SETUP, HALF_DIV cycles:
  - spi_csn[cs_sel] = 0; if cs_sel >= NUM_CS, all csn stay 1 and the frame still runs (dummy frame).
  - spi_clk = cpol.
  - CPHA=0: spi_mosi = first bit on SETUP entry.
- XFER:
  - 2*DATA_W spi_clk edges, one every HALF_DIV cycles (half-period counter reloads on each edge).
  - Odd edges are leading, even edges are trailing.
  - CPHA=0: sample spi_miso on leading edges; shift the next bit onto spi_mosi on trailing edges, except the final trailing edge.
  - CPHA=1: shift on leading edges (first bit driven on edge 1); sample on trailing edges.
  - Bit counter is DATA_W-wide-safe (clog2(DATA_W)+1 bits). XFER exits after edge 2*DATA_W, leaving spi_clk = cpol.
- HOLD, HALF_DIV cycles: spi_clk = cpol, csn still low. On exit all csn go 1 and spi_mosi goes 0.
- GAP, GAP_CYC cycles: csn all 1. On the last GAP cycle, rx_data is loaded from the shift register and done pulses for 1 cycle. busy drops in the same cycle done rises; next state is IDLE.
- Latency: done rises exactly HALF_DIV + 2*DATA_W*HALF_DIV + HALF_DIV + GAP_CYC cycles after the sys_clk edge that samples start.
- Back-to-back: start held high in the IDLE cycle after done begins the next frame. Minimum 1 IDLE cycle between frames.
- rx_data holds its value between frames. Inputs changing during a frame have no effect.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: adds input lsb_first (1 bit, latched at start). When the latched value is 1, tx is shifted out bit 0 first and rx is assembled bit 0 first.
- Undefined: the port is absent; frames are always MSB first (tx bit DATA_W-1 first; first received bit lands in rx_data[DATA_W-1]).

Test Plan:
- Mode 0 loopback (miso tied to mosi), DATA_W=16, HALF_DIV=2, GAP_CYC=8, cs_sel=1, tx=0xA55A -> spi_csn=4'b1101 during frame, 16 rising edges, rx_data=0xA55A, done exactly 76 cycles after start.
- All modes with a slave model returning 0x3C0F for each cpol/cpha pair -> rx_data=0x3C0F each time; spi_clk idles at cpol; mosi stable around every sampling edge.
- Busy rejection: start pulsed again 10 cycles into a frame -> ignored, exactly one done, no second CS assertion.
- Reset mid-frame: rst at XFER bit 5 -> spi_csn=all 1, spi_clk=0, busy=0 within the same cycle. Next start completes normally with rx_data correct.
- Dummy slave: cs_sel=3 with NUM_CS=3 -> all csn stay 1, spi_clk toggles 2*DATA_W times, done still pulses.
- SPI_LSB_FIRST_EN defined, lsb_first=1, tx=0x0001 -> mosi high only on the first bit; loopback rx_data=0x0001.

Source files
------------

// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised full-duplex SPI master.
// Configurable word width, clock divider, CPOL/CPHA per frame, several chip
// selects and programmable CS setup/hold/gap timing.
// Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first input
// (bit-order select, latched at start). Without it frames are MSB first.
module spi_master_multi #(
  parameter int DATA_W   = 16,
  parameter int HALF_DIV = 25,
  parameter int NUM_CS   = 4,
  parameter int GAP_CYC  = 8,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic [NUM_CS-1:0] spi_csn,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  // One counter serves both the half-period timer and the gap timer.
  localparam int CNT_MAX = (HALF_DIV > GAP_CYC) ? HALF_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W) + 1;

  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state_reg,   state_next;
  logic [CNT_W-1:0]    cnt_reg,     cnt_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]   tx_sh_reg,   tx_sh_next;
  logic [DATA_W-1:0]   rx_sh_reg,   rx_sh_next;
  logic [DATA_W-1:0]   rx_data_reg, rx_data_next;
  logic                cpol_reg,    cpol_next;
  logic                cpha_reg,    cpha_next;
  logic                lsb_reg,     lsb_next;
  logic                clk_reg,     clk_next;
  logic                mosi_reg,    mosi_next;
  logic [NUM_CS-1:0]   csn_reg,     csn_next;
  logic                busy_reg,    busy_next;
  logic                done_reg,    done_next;

  logic                lsb_in;
  logic [NUM_CS-1:0]   csn_decode;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // Active-low one-hot decode of the requested slave; an out-of-range index
  // matches no line, so the frame runs with every select deasserted.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_decode
      assign csn_decode[gi] = (cs_sel != CS_W'(gi));
    end
  endgenerate

  // Bit that goes out next from a transmit word, given the bit order.
  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Transmit word with its head bit consumed.
  function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // Receive word with one more sampled bit appended in frame order.
  function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] w, input logic lsb,
                                                  input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Next-state and next-output logic for the whole frame sequencer.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    tx_sh_next   = tx_sh_reg;
    rx_sh_next   = rx_sh_reg;
    rx_data_next = rx_data_reg;
    cpol_next    = cpol_reg;
    cpha_next    = cpha_reg;
    lsb_next     = lsb_reg;
    clk_next     = clk_reg;
    mosi_next    = mosi_reg;
    csn_next     = csn_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        clk_next = cpol_reg;
        csn_next = '1;
        if (start) begin
          state_next   = SETUP;
          cnt_next     = HALF_RELOAD;
          bit_cnt_next = '0;
          cpol_next    = cpol;
          cpha_next    = cpha;
          lsb_next     = lsb_in;
          clk_next     = cpol;
          csn_next     = csn_decode;
          busy_next    = 1'b1;
          // CPHA=0 needs the first bit on the line before the first edge.
          if (!cpha) begin
            mosi_next  = head_bit(tx_data, lsb_in);
            tx_sh_next = drop_head(tx_data, lsb_in);
          end else begin
            tx_sh_next = tx_data;
          end
        end
      end

      SETUP: begin
        if (cnt_reg == '0) begin
          state_next = XFER;
          cnt_next   = HALF_RELOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      XFER: begin
        if (cnt_reg == '0) begin
          cnt_next = HALF_RELOAD;
          clk_next = ~clk_reg;
          if (clk_reg == cpol_reg) begin
            // Leading edge.
            if (!cpha_reg) begin
              rx_sh_next = push_bit(rx_sh_reg, lsb_reg, spi_miso);
            end else begin
              mosi_next  = head_bit(tx_sh_reg, lsb_reg);
              tx_sh_next = drop_head(tx_sh_reg, lsb_reg);
            end
          end else begin
            // Trailing edge; it closes one bit.
            if (!cpha_reg) begin
              if (bit_cnt_reg != LAST_BIT) begin
                mosi_next  = head_bit(tx_sh_reg, lsb_reg);
                tx_sh_next = drop_head(tx_sh_reg, lsb_reg);
              end
            end else begin
              rx_sh_next = push_bit(rx_sh_reg, lsb_reg, spi_miso);
            end
            if (bit_cnt_reg == LAST_BIT) begin
              state_next = HOLD;
            end else begin
              bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            end
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      HOLD: begin
        if (cnt_reg == '0) begin
          state_next = GAP;
          cnt_next   = GAP_RELOAD;
          csn_next   = '1;
          mosi_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_reg == '0) begin
          state_next   = IDLE;
          rx_data_next = rx_sh_reg;
          done_next    = 1'b1;
          busy_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        csn_next   = '1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      tx_sh_reg   <= '0;
      rx_sh_reg   <= '0;
      rx_data_reg <= '0;
      cpol_reg    <= 1'b0;
      cpha_reg    <= 1'b0;
      lsb_reg     <= 1'b0;
      clk_reg     <= 1'b0;
      mosi_reg    <= 1'b0;
      csn_reg     <= '1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_sh_reg   <= tx_sh_next;
      rx_sh_reg   <= rx_sh_next;
      rx_data_reg <= rx_data_next;
      cpol_reg    <= cpol_next;
      cpha_reg    <= cpha_next;
      lsb_reg     <= lsb_next;
      clk_reg     <= clk_next;
      mosi_reg    <= mosi_next;
      csn_reg     <= csn_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign rx_data  = rx_data_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign spi_csn  = csn_reg;
  assign spi_clk  = clk_reg;
  assign spi_mosi = mosi_reg;

endmodule

// File: tb/tb_spi_master_multi.sv
// Testbench for spi_master_multi: table of frames across all SPI modes,
// loopback and slave-model data, a dummy chip select, plus hand-written
// sequences for start-while-busy, asynchronous reset mid-frame and the
// optional LSB-first build.
module tb_spi_master_multi;

  localparam int EXP_LAT = 2 + 2 * 16 * 2 + 2 + 8;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [1:0]  cs_sel = 2'd0;
  logic [15:0] tx_data = 16'h0000;
`ifdef SPI_LSB_FIRST_EN
  logic        lsb_first = 1'b0;
`endif
  logic [15:0] rx_data;
  logic        busy;
  logic        done;
  logic [2:0]  spi_csn;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;

  // Bench-side frame context and slave model state
  logic        t_cpol = 1'b0;
  logic        t_cpha = 1'b0;
  logic [1:0]  t_sel = 2'd0;
  logic        loop_en = 1'b1;
  logic [15:0] slv_word = 16'h3C0F;
  logic [15:0] slv_sh = 16'h0000;
  logic        slv_miso = 1'b0;
  int          frame_id = 0;
  int          seen_id = 0;

  // Monitor results
  int          mon_edges = 0;
  int          mon_rise = 0;
  int          mon_bad = 0;
  int          cs_asserts = 0;
  int          dones = 0;
  logic [15:0] mon_tx = 16'h0000;
  logic        prev_clk = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_mosi = 1'b0;
  logic        prev_all1 = 1'b1;
  logic        prev_act = 1'b0;
  logic        act;
  logic        lead;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  assign spi_miso = loop_en ? spi_mosi : slv_miso;

  spi_master_multi #(
    .DATA_W  (16),
    .HALF_DIV(2),
    .NUM_CS  (3),
    .GAP_CYC (8)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .start    (start),
    .cpol     (cpol),
    .cpha     (cpha),
    .cs_sel   (cs_sel),
    .tx_data  (tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done),
    .spi_csn  (spi_csn),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  // Bus monitor plus behavioural slave; all observation on the falling edge.
  always @(negedge sys_clk) begin
    act = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == int'(t_sel) && !spi_csn[i]) act = 1'b1;
    end
    if (frame_id != seen_id) begin
      seen_id    = frame_id;
      mon_edges  = 0;
      mon_rise   = 0;
      mon_bad    = 0;
      cs_asserts = 0;
      dones      = 0;
      mon_tx     = 16'h0000;
      if (!t_cpha) begin
        slv_miso = slv_word[15];
        slv_sh   = {slv_word[14:0], 1'b0};
      end else begin
        slv_miso = 1'b0;
        slv_sh   = slv_word;
      end
    end else begin
      lead = (spi_clk != t_cpol);
      if (prev_busy && busy && spi_clk !== prev_clk) begin
        mon_edges++;
        if (spi_clk) mon_rise++;
        if (lead != t_cpha) begin
          if (spi_mosi !== prev_mosi) mon_bad++;
          mon_tx = {mon_tx[14:0], spi_mosi};
        end
      end
      if (prev_act && act && spi_clk !== prev_clk && lead == t_cpha) begin
        slv_miso = slv_sh[15];
        slv_sh   = {slv_sh[14:0], 1'b0};
      end
      if (prev_all1 && !(&spi_csn)) cs_asserts++;
      if (done) dones++;
    end
    prev_clk  = spi_clk;
    prev_busy = busy;
    prev_mosi = spi_mosi;
    prev_all1 = &spi_csn;
    prev_act  = act;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Runs one frame; returns cycles from the accepting edge to done and the
  // chip-select pattern seen mid-transfer. inject re-pulses start mid-frame.
  task automatic run_frame(input logic cp, input logic ph, input logic [1:0] sel,
                           input logic [15:0] tx, input logic lp, input bit inject,
                           output int lat, output logic [2:0] csn_mid);
    int n;
    @(negedge sys_clk);
    t_cpol  = cp;
    t_cpha  = ph;
    t_sel   = sel;
    loop_en = lp;
    frame_id++;
    @(negedge sys_clk);
    cpol    = cp;
    cpha    = ph;
    cs_sel  = sel;
    tx_data = tx;
    start   = 1'b1;
    @(negedge sys_clk);
    start   = 1'b0;
    n       = 0;
    csn_mid = 3'b000;
    while (done !== 1'b1 && n < 300) begin
      @(negedge sys_clk);
      n++;
      if (n == 5) csn_mid = spi_csn;
      if (n == 10) begin
        tx_data = ~tx;
        cpol    = ~cp;
        cpha    = ~ph;
        cs_sel  = ~sel;
        if (inject) start = 1'b1;
      end
      if (n == 11) start = 1'b0;
    end
    lat = n;
  endtask

  typedef struct {
    logic        cp;
    logic        ph;
    logic [1:0]  sel;
    logic [15:0] tx;
    logic        lp;
    logic [15:0] exp_rx;
    logic [2:0]  exp_csn;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    logic [2:0] csn_mid;
    int n;

    vecs[0] = '{1'b0, 1'b0, 2'd1, 16'hA55A, 1'b1, 16'hA55A, 3'b101};
    vecs[1] = '{1'b0, 1'b0, 2'd0, 16'h1234, 1'b0, 16'h3C0F, 3'b110};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 16'hC3A5, 1'b0, 16'h3C0F, 3'b101};
    vecs[3] = '{1'b1, 1'b0, 2'd2, 16'h0F0F, 1'b0, 16'h3C0F, 3'b011};
    vecs[4] = '{1'b1, 1'b1, 2'd0, 16'h8001, 1'b0, 16'h3C0F, 3'b110};
    vecs[5] = '{1'b0, 1'b1, 2'd3, 16'h5AC3, 1'b1, 16'h5AC3, 3'b111};
    vecs[6] = '{1'b1, 1'b1, 2'd2, 16'hFFFE, 1'b1, 16'hFFFE, 3'b011};

    // Reset values while reset is held
    repeat (3) @(negedge sys_clk);
    check("reset_csn", 32'(spi_csn), 32'h7);
    check("reset_clk", 32'(spi_clk), 32'h0);
    check("reset_mosi", 32'(spi_mosi), 32'h0);
    check("reset_rx", 32'(rx_data), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Table of frames
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].cp, vecs[v].ph, vecs[v].sel, vecs[v].tx, vecs[v].lp, 1'b0, lat, csn_mid);
      $display("frame %0d: cpol=%0d cpha=%0d sel=%0d tx=%h rx=%h lat=%0d csn=%b edges=%0d",
               v, vecs[v].cp, vecs[v].ph, vecs[v].sel, vecs[v].tx, rx_data, lat, csn_mid, mon_edges);
      check("latency", 32'(lat), 32'(EXP_LAT));
      check("rx_data", 32'(rx_data), 32'(vecs[v].exp_rx));
      check("busy_at_done", 32'(busy), 32'h0);
      check("csn_mid", 32'(csn_mid), 32'(vecs[v].exp_csn));
      check("clk_edges", 32'(mon_edges), 32'd32);
      check("clk_rises", 32'(mon_rise), 32'd16);
      check("mosi_bits", 32'(mon_tx), 32'(vecs[v].tx));
      check("mosi_stable", 32'(mon_bad), 32'h0);
      @(negedge sys_clk);
      check("done_pulse", 32'(done), 32'h0);
      check("clk_idle", 32'(spi_clk), 32'(vecs[v].cp));
      check("csn_idle", 32'(spi_csn), 32'h7);
      check("done_count", 32'(dones), 32'h1);
      check("cs_asserts", 32'(cs_asserts), (vecs[v].exp_csn == 3'b111) ? 32'h0 : 32'h1);
    end

    // Start re-pulsed 10 cycles into a frame must be ignored
    run_frame(1'b0, 1'b0, 2'd1, 16'h1357, 1'b1, 1'b1, lat, csn_mid);
    repeat (120) @(negedge sys_clk);
    $display("busy-reject: lat=%0d rx=%h dones=%0d cs_asserts=%0d", lat, rx_data, dones, cs_asserts);
    check("reject_latency", 32'(lat), 32'(EXP_LAT));
    check("reject_rx", 32'(rx_data), 32'h1357);
    check("reject_dones", 32'(dones), 32'h1);
    check("reject_cs", 32'(cs_asserts), 32'h1);
    check("reject_busy", 32'(busy), 32'h0);

    // Asynchronous reset during bit 5 of a mode-3 frame
    @(negedge sys_clk);
    t_cpol  = 1'b1;
    t_cpha  = 1'b1;
    t_sel   = 2'd2;
    loop_en = 1'b0;
    frame_id++;
    @(negedge sys_clk);
    cpol    = 1'b1;
    cpha    = 1'b1;
    cs_sel  = 2'd2;
    tx_data = 16'h9999;
    start   = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    n = 0;
    while (mon_edges < 10 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("reset_reach_bit5", 32'(mon_edges), 32'd10);
    @(posedge sys_clk);
    #2 rst = 1'b1;
    #1;
    $display("reset mid-frame: csn=%b clk=%0d busy=%0d", spi_csn, spi_clk, busy);
    check("abort_csn", 32'(spi_csn), 32'h7);
    check("abort_clk", 32'(spi_clk), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rx", 32'(rx_data), 32'h0);
    @(negedge sys_clk);
    rst = 1'b0;
    run_frame(1'b0, 1'b0, 2'd0, 16'h6B2D, 1'b1, 1'b0, lat, csn_mid);
    $display("after reset: rx=%h lat=%0d", rx_data, lat);
    check("post_reset_latency", 32'(lat), 32'(EXP_LAT));
    check("post_reset_rx", 32'(rx_data), 32'h6B2D);
    check("post_reset_csn", 32'(csn_mid), 32'h6);

`ifdef SPI_LSB_FIRST_EN
    // LSB first: only the first bit on mosi is high
    lsb_first = 1'b1;
    run_frame(1'b0, 1'b0, 2'd1, 16'h0001, 1'b1, 1'b0, lat, csn_mid);
    $display("lsb-first: rx=%h mosi_bits=%h lat=%0d", rx_data, mon_tx, lat);
    check("lsb_latency", 32'(lat), 32'(EXP_LAT));
    check("lsb_rx", 32'(rx_data), 32'h0001);
    check("lsb_mosi_bits", 32'(mon_tx), 32'h8000);
    lsb_first = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
